// File: rtl/sub_64_seq.sv
// Multi-cycle 64-bit subtractor: a + ~b + 1 computed one CHUNK_W slice per cycle, LSB slice first.
// Define SUB64_FLAGS_EN to register Y86 zf/sf/of; otherwise they are tied low.
module sub_64_seq #(
    parameter int CHUNK_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] diff,
    output logic        borrow,
    output logic        zf,
    output logic        sf,
    output logic        of
);

    localparam int N     = 64 / CHUNK_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    // Handshake: an operand pair transfers on an edge with in_valid && in_ready;
    // a result transfers on an edge with out_valid && out_ready. No overlap between the two.
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t r_state;
    state_t w_state_next;

    logic [63:0]        r_a;
    logic [63:0]        r_nb;
    logic [63:0]        r_diff;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;
    logic               r_borrow;

    logic [CHUNK_W-1:0] w_a_sl;
    logic [CHUNK_W-1:0] w_nb_sl;
    logic [CHUNK_W:0]   w_sum;
    logic [63:0]        w_diff_next;
    logic               w_last;

    assign w_last    = (r_idx == LAST_IDX);
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign diff      = r_diff;
    assign borrow    = r_borrow;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_next = BUSY;
            BUSY:    if (w_last)    w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default:                w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_a_sl  = '0;
        w_nb_sl = '0;
        for (int s = 0; s < N; s++) begin
            if (r_idx == IDX_W'(s)) begin
                w_a_sl  = r_a[s*CHUNK_W +: CHUNK_W];
                w_nb_sl = r_nb[s*CHUNK_W +: CHUNK_W];
            end
        end
    end

    assign w_sum = {1'b0, w_a_sl} + {1'b0, w_nb_sl} + {{CHUNK_W{1'b0}}, r_carry};

    // Full result as it will look after this edge, so flags can see the top slice.
    always_comb begin
        w_diff_next = r_diff;
        for (int s = 0; s < N; s++) begin
            if (r_idx == IDX_W'(s)) w_diff_next[s*CHUNK_W +: CHUNK_W] = w_sum[CHUNK_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_nb     <= '0;
            r_diff   <= '0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            r_borrow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_nb    <= ~b;
                        r_carry <= 1'b1;
                        r_idx   <= '0;
                    end
                end
                BUSY: begin
                    r_diff  <= w_diff_next;
                    r_carry <= w_sum[CHUNK_W];
                    r_idx   <= r_idx + IDX_W'(1);
                    if (w_last) r_borrow <= ~w_sum[CHUNK_W];
                end
                default: ;
            endcase
        end
    end

`ifdef SUB64_FLAGS_EN
    logic r_zf;
    logic r_sf;
    logic r_of;

    // b[63] is ~r_nb[63], so "a and b signs differ" becomes r_a[63] == r_nb[63].
    always_ff @(posedge clk) begin
        if (rst) begin
            r_zf <= 1'b0;
            r_sf <= 1'b0;
            r_of <= 1'b0;
        end else if (r_state == BUSY && w_last) begin
            r_zf <= (w_diff_next == 64'd0);
            r_sf <= w_diff_next[63];
            r_of <= (r_a[63] == r_nb[63]) && (w_diff_next[63] != r_a[63]);
        end
    end

    assign zf = r_zf;
    assign sf = r_sf;
    assign of = r_of;
`else
    assign zf = 1'b0;
    assign sf = 1'b0;
    assign of = 1'b0;
`endif

endmodule

// File: tb/tb_sub_64_seq.sv
// Bench for sub_64_seq: four instances (CHUNK_W 8/16/32/64), directed vectors on the
// 16-bit instance, then a random sweep over all widths.
module tb_sub_64_seq;

`ifdef SUB64_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid_v  [4];
    logic        out_ready_v [4];
    logic        in_ready_v  [4];
    logic        out_valid_v [4];
    logic        borrow_v    [4];
    logic        zf_v        [4];
    logic        sf_v        [4];
    logic        of_v        [4];
    logic [63:0] a_v         [4];
    logic [63:0] b_v         [4];
    logic [63:0] diff_v      [4];

    int n_cmp = 0;
    int n_err = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sub_64_seq #(.CHUNK_W(8 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid_v[g]),
            .in_ready  (in_ready_v[g]),
            .a         (a_v[g]),
            .b         (b_v[g]),
            .out_valid (out_valid_v[g]),
            .out_ready (out_ready_v[g]),
            .diff      (diff_v[g]),
            .borrow    (borrow_v[g]),
            .zf        (zf_v[g]),
            .sf        (sf_v[g]),
            .of        (of_v[g])
        );
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_result(input int k, input string tag, input logic [63:0] ed,
                                input logic eb, input logic ez, input logic es, input logic eo);
        check($sformatf("%s_valid", tag), out_valid_v[k], 1);
        check($sformatf("%s_ready", tag), in_ready_v[k], 0);
        check($sformatf("%s_diff", tag), diff_v[k], ed);
        check($sformatf("%s_borrow", tag), borrow_v[k], eb);
        check($sformatf("%s_zf", tag), zf_v[k], FLAGS_ON ? ez : 1'b0);
        check($sformatf("%s_sf", tag), sf_v[k], FLAGS_ON ? es : 1'b0);
        check($sformatf("%s_of", tag), of_v[k], FLAGS_ON ? eo : 1'b0);
    endtask

    // One full transaction on instance k; operands are scrambled right after acceptance.
    task automatic run_op(input int k, input logic [63:0] av, input logic [63:0] bv,
                          input int stall, input logic [63:0] ed, input logic eb,
                          input logic ez, input logic es, input logic eo,
                          input int elat, input string tag);
        int lat;
        a_v[k]         = av;
        b_v[k]         = bv;
        in_valid_v[k]  = 1'b1;
        out_ready_v[k] = (stall == 0);
        @(posedge clk); #1;
        in_valid_v[k] = 1'b0;
        a_v[k]        = ~av;
        b_v[k]        = ~bv ^ 64'h5A5A;
        check($sformatf("%s_busy_ready", tag), in_ready_v[k], 0);
        lat = 0;
        while (!out_valid_v[k] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("%s_latency", tag), 64'(lat), 64'(elat));
        check_result(k, tag, ed, eb, ez, es, eo);
        for (int c = 0; c < stall; c++) begin
            @(posedge clk); #1;
            check_result(k, $sformatf("%s_stall%0d", tag, c), ed, eb, ez, es, eo);
        end
        out_ready_v[k] = 1'b1;
        @(posedge clk); #1;
        check($sformatf("%s_idle_ready", tag), in_ready_v[k], 1);
        check($sformatf("%s_idle_valid", tag), out_valid_v[k], 0);
        out_ready_v[k] = 1'b0;
    endtask

    initial begin
        logic [63:0] av, bv, ed;
        for (int k = 0; k < 4; k++) begin
            in_valid_v[k]  = 1'b0;
            out_ready_v[k] = 1'b0;
            a_v[k]         = '0;
            b_v[k]         = '0;
        end

        // Reset with in_valid asserted: reset must win.
        rst           = 1'b1;
        in_valid_v[1] = 1'b1;
        a_v[1]        = 64'h99;
        out_ready_v[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rst%0d_ready", k), in_ready_v[k], 1);
            check($sformatf("rst%0d_valid", k), out_valid_v[k], 0);
            check($sformatf("rst%0d_diff", k), diff_v[k], 0);
            check($sformatf("rst%0d_borrow", k), borrow_v[k], 0);
            check($sformatf("rst%0d_flags", k), {zf_v[k], sf_v[k], of_v[k]}, 0);
        end
        in_valid_v[1]  = 1'b0;
        out_ready_v[1] = 1'b0;
        rst            = 1'b0;
        @(posedge clk); #1;

        run_op(1, 64'h3C, 64'h25, 0, 64'h17, 0, 0, 0, 0, 4, "basic");
        run_op(1, 64'h5, 64'h8, 0, 64'hFFFF_FFFF_FFFF_FFFD, 1, 0, 1, 0, 4, "neg");
        run_op(1, 64'h8000_0000_0000_0000, 64'h1, 0, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 0, 1, 4, "ovf");
        run_op(1, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 5, 64'h0, 0, 1, 0, 0, 4, "eq_stall");
        run_op(1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'h1, 1, 0, 0, 0, 4, "wrap");

        // Reset during the second BUSY cycle discards the operation.
        a_v[1]         = 64'hFF;
        b_v[1]         = 64'h1;
        in_valid_v[1]  = 1'b1;
        out_ready_v[1] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_ready", in_ready_v[1], 1);
        check("midrst_valid", out_valid_v[1], 0);
        check("midrst_diff", diff_v[1], 0);
        @(posedge clk); #1;
        check("midrst_still_idle", out_valid_v[1], 0);
        run_op(1, 64'h10, 64'h1, 0, 64'hF, 0, 0, 0, 0, 4, "after_rst");

        // Borrow ripple across every slice boundary, on every width.
        for (int k = 0; k < 4; k++) begin
            run_op(k, 64'h0000_0001_0000_0000, 64'h1, 0, 64'h0000_0000_FFFF_FFFF, 0, 0, 0, 0,
                   64 / (8 << k), $sformatf("ripple_w%0d", 8 << k));
            run_op(k, 64'h0, 64'h1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 1, 0,
                   64 / (8 << k), $sformatf("m1_w%0d", 8 << k));
        end

        // Random sweep against a reference subtract.
        for (int k = 0; k < 4; k++) begin
            for (int t = 0; t < 6; t++) begin
                av = {$urandom, $urandom};
                bv = {$urandom, $urandom};
                if (t == 2) bv = {av[63:32], bv[31:0]};
                ed = av - bv;
                run_op(k, av, bv, $urandom_range(0, 2), ed, (av < bv), (ed == 64'd0), ed[63],
                       (av[63] != bv[63]) && (ed[63] != av[63]),
                       64 / (8 << k), $sformatf("rnd_w%0d_%0d", 8 << k, t));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sub_64_seq.md
SUB_64_SEQ -- requirements
Module: sub_64_seq

Interface
REQ-001 The module SHALL have parameter: CHUNK_W, 16, bits processed per cycle; legal values 8, 16, 32 and 64.
REQ-002 The module SHALL have port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 The module SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-004 The module SHALL have port: in_valid  input  1  operands a/b present.
REQ-005 The module SHALL have port: in_ready  output  1  block able to accept operands.
REQ-006 The module SHALL have port: a  input  64  minuend.
REQ-007 The module SHALL have port: b  input  64  subtrahend.
REQ-008 The module SHALL have port: out_valid  output  1  result available.
REQ-009 The module SHALL have port: out_ready  input  1  consumer accepts result.
REQ-010 The module SHALL have port: diff  output  64  a - b, modulo 2^64.
REQ-011 The module SHALL have port: borrow  output  1  1 iff a < b (unsigned).
REQ-012 The module SHALL have ports: zf, sf, of  output  1 each  Y86 condition flags for the subtraction.

Function
REQ-013 The block SHALL compute diff as a + ~b + 1 through one CHUNK_W-bit slice per cycle, least-significant slice first, with the carry registered between slices.
REQ-014 The FSM SHALL have states IDLE, BUSY and DONE; in_ready = (state==IDLE) and out_valid = (state==DONE).
REQ-015 In IDLE, when in_valid=1 at an edge, the block SHALL latch a and ~b, set carry to 1, clear the slice index and enter BUSY; when in_valid=0 it SHALL remain in IDLE.
REQ-016 In BUSY, each edge SHALL produce one slice of diff and increment the index; the edge that produces slice N-1 (N=64/CHUNK_W) SHALL enter DONE.
REQ-017 Latency SHALL be N cycles: out_valid rises exactly N edges after the accepting edge (N=4 at default).
REQ-018 borrow SHALL equal the inverse of the final carry out of bit 63.
REQ-019 In DONE, diff, borrow, zf, sf and of SHALL hold stable until out_ready=1 is sampled; that edge SHALL return the block to IDLE.
REQ-020 There SHALL be no overlap: in_ready=0 in BUSY and DONE, and in_valid is ignored there; changes to a or b after acceptance SHALL NOT affect the result.
REQ-021 Throughput SHALL be one result per N+2 cycles when out_ready is held at 1 (accept, N BUSY edges, drain).
REQ-022 CHUNK_W=64 SHALL give one BUSY cycle (N=1); all other behaviour is unchanged.

Reset
REQ-023 When rst=1 at an edge, the block SHALL enter IDLE, and diff, borrow, zf, sf, of, the carry and the index SHALL clear to 0, from any state including mid-BUSY; the in-flight operation SHALL be discarded.
REQ-024 After reset, in_ready SHALL be 1 and out_valid SHALL be 0; rst SHALL take priority over in_valid and out_ready.

Configuration
REQ-025 With macro SUB64_FLAGS_EN defined, the flags SHALL be registered on entry to DONE as: zf = (diff==0); sf = diff[63]; of = (a[63]!=b[63]) && (diff[63]!=a[63]).
REQ-026 Without SUB64_FLAGS_EN, zf, sf and of SHALL be tied to 0 and no flag logic SHALL be synthesized; ports and all other behaviour remain identical.

Verification
REQ-027 a=0x3C, b=0x25, out_ready=1 -> out_valid 4 cycles after accept; diff=0x17; borrow=0; zf=0; sf=0; of=0.
REQ-028 a=0x5, b=0x8 -> diff=0xFFFFFFFFFFFFFFFD; borrow=1; sf=1; of=0.
REQ-029 a=0x8000000000000000, b=0x1 -> diff=0x7FFFFFFFFFFFFFFF; borrow=0; of=1; sf=0.
REQ-030 a=b=0x123456789ABCDEF0, with out_ready held 0 for 5 cycles -> diff=0, zf=1, outputs stable and in_ready=0 throughout the stall; return to IDLE one edge after out_ready=1.
REQ-031 rst pulsed on the 2nd BUSY cycle -> next cycle IDLE, out_valid=0, diff=0; a new operation (a=0x10, b=0x1) then yields diff=0xF.
REQ-032 Sweep CHUNK_W over 8, 16, 32 and 64 with random operands -> diff and borrow match the reference model; latency = 64/CHUNK_W.
